// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch front-end.
// Issues in-order word fetches to a variable-latency instruction memory and
// buffers the returned words, each tagged with its PC, in a DEPTH-entry queue.
// Decode drains the queue over instr_valid/instr_ready. A redirect flushes the
// queue, marks every in-flight request as stale and restarts fetch at the target.
//
// Ports:
//   clk, rst                        clock, synchronous active-high reset
//   imem_req_valid/ready, imem_addr request channel to instruction memory
//   imem_rsp_valid, imem_rsp_data   in-order responses, latency >= 1
//   redirect, redirect_pc           flush and restart (pc[1:0] ignored)
//   instr_valid/ready, instr,       queue head presented to decode
//   instr_pc
module fetch_unit #(
  parameter int           N        = 32,
  parameter logic [N-1:0] RESET_PC = '0,
  parameter int           DEPTH    = 2
) (
  input  logic         clk,
  input  logic         rst,
  output logic         imem_req_valid,
  input  logic         imem_req_ready,
  output logic [N-1:0] imem_addr,
  input  logic         imem_rsp_valid,
  input  logic [N-1:0] imem_rsp_data,
  input  logic         redirect,
  input  logic [N-1:0] redirect_pc,
  output logic         instr_valid,
  input  logic         instr_ready,
  output logic [N-1:0] instr,
  output logic [N-1:0] instr_pc
);

  localparam int             PW         = $clog2(DEPTH);
  localparam int             CW         = $clog2(DEPTH + 1);
  localparam logic [CW-1:0]  ONE_C      = CW'(1);
  localparam logic [PW-1:0]  ONE_P      = PW'(1);
  localparam logic [CW:0]    DEPTH_C    = (CW + 1)'(DEPTH);
  localparam logic [N-1:0]   PC_STEP    = N'(4);
  localparam logic [N-1:0]   RESET_PC_A = RESET_PC & ~N'(3);

  function automatic logic [N-1:0] align_word(input logic [N-1:0] a);
    return a & ~N'(3);
  endfunction

  logic [N-1:0]  fetch_pc_q, fetch_pc_d;
  logic [N-1:0]  rsp_pc_q,   rsp_pc_d;
  logic [CW-1:0] outst_q,    outst_d;
  logic [CW-1:0] drop_q,     drop_d;
  logic [CW-1:0] count_q,    count_d;
  logic [PW-1:0] rd_q,       rd_d;
  logic [PW-1:0] wr_q,       wr_d;
  logic [N-1:0]  buf_instr_q [DEPTH];
  logic [N-1:0]  buf_pc_q    [DEPTH];

  logic [CW:0]   inflight;
  logic          req_acc;
  logic          rsp_live;
  logic          push;
  logic          pop;

  // Credits cover both in-flight requests and buffered words, so the queue
  // can never overflow whatever the memory latency.
  assign inflight       = {1'b0, outst_q} + {1'b0, count_q};
  assign imem_req_valid = !rst && !redirect && (inflight < DEPTH_C);
  assign imem_addr      = fetch_pc_q;
  assign req_acc        = imem_req_valid && imem_req_ready;

  // Responses with nothing outstanding (e.g. left over from before a reset)
  // are ignored entirely.
  assign rsp_live = imem_rsp_valid && (outst_q != '0);
  assign push     = rsp_live && (drop_q == '0) && !redirect;

  assign instr_valid = !rst && (count_q != '0);
  assign pop         = instr_valid && instr_ready;
  assign instr       = buf_instr_q[rd_q];
  assign instr_pc    = buf_pc_q[rd_q];

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    rsp_pc_d   = rsp_pc_q;
    outst_d    = outst_q;
    drop_d     = drop_q;
    count_d    = count_q;
    rd_d       = rd_q;
    wr_d       = wr_q;
    if (redirect) begin
      fetch_pc_d = align_word(redirect_pc);
      rsp_pc_d   = align_word(redirect_pc);
      rd_d       = '0;
      wr_d       = '0;
      count_d    = '0;
      // Everything still in flight after this cycle's response is stale.
      outst_d    = outst_q - (rsp_live ? ONE_C : '0);
      drop_d     = outst_q - (rsp_live ? ONE_C : '0);
    end else begin
      if (req_acc) begin
        fetch_pc_d = fetch_pc_q + PC_STEP;
      end
      outst_d = outst_q + (req_acc ? ONE_C : '0) - (rsp_live ? ONE_C : '0);
      if (rsp_live && (drop_q != '0)) begin
        drop_d = drop_q - ONE_C;
      end
      if (push) begin
        wr_d     = wr_q + ONE_P;
        rsp_pc_d = rsp_pc_q + PC_STEP;
      end
      if (pop) begin
        rd_d = rd_q + ONE_P;
      end
      count_d = count_q + (push ? ONE_C : '0) - (pop ? ONE_C : '0);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC_A;
      rsp_pc_q   <= RESET_PC_A;
      outst_q    <= '0;
      drop_q     <= '0;
      count_q    <= '0;
      rd_q       <= '0;
      wr_q       <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      rsp_pc_q   <= rsp_pc_d;
      outst_q    <= outst_d;
      drop_q     <= drop_d;
      count_q    <= count_d;
      rd_q       <= rd_d;
      wr_q       <= wr_d;
    end
  end

  // Queue storage carries data only; validity lives in count_q.
  always_ff @(posedge clk) begin
    if (push) begin
      buf_instr_q[wr_q] <= imem_rsp_data;
      buf_pc_q[wr_q]    <= rsp_pc_q;
    end
  end

endmodule
